// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 burst slave backed by a word-addressed on-chip memory array
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*       write address, write data and write response channels
//   S_AXI_AR*/R*          read address and read data channels
// One write burst and one read burst may be outstanding; the two paths run independently.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 1024,
    parameter int READ_LATENCY   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [7:0]                  S_AXI_AWLEN,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    input  logic                        S_AXI_WLAST,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [7:0]                  S_AXI_ARLEN,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic                        S_AXI_RLAST,
    input  logic                        S_AXI_RREADY
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ONE_A   = AXI_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t                   r_wstate, w_wnext;
    logic                      r_awready, r_wready, r_bvalid, r_werr;
    logic [AXI_ID_WIDTH-1:0]   r_awid;
    logic [AXI_ADDR_WIDTH-1:0] r_widx;
    logic [1:0]                r_wburst;
    logic [7:0]                r_wlen, r_wcnt;
    logic                      w_aw_hs, w_w_hs, w_b_hs, w_win, w_wlast_beat, w_wend;

    rstate_t                   r_rstate, w_rnext;
    logic                      r_arready, r_rvalid, r_rlast;
    logic [AXI_ID_WIDTH-1:0]   r_arid;
    logic [AXI_ADDR_WIDTH-1:0] r_ridx;
    logic [1:0]                r_rburst, r_rresp;
    logic [7:0]                r_rlen, r_rcnt;
    logic [15:0]               r_lat;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic                      w_ar_hs, w_r_hs, w_rload, w_rin;
    logic [AXI_ADDR_WIDTH-1:0] w_lidx;
    logic [7:0]                w_lcnt;

    // Beat size is fixed at the full data width, so the size fields carry no information here.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    assign w_aw_hs      = r_awready & S_AXI_AWVALID;
    assign w_w_hs       = r_wready & S_AXI_WVALID;
    assign w_b_hs       = r_bvalid & S_AXI_BREADY;
    assign w_win        = r_widx < DEPTH_A;
    assign w_wlast_beat = r_wcnt == r_wlen;
    assign w_wend       = S_AXI_WLAST | w_wlast_beat;

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  w_wnext = w_aw_hs ? W_DATA : W_IDLE;
            W_DATA:  w_wnext = (w_w_hs && w_wend) ? W_RESP : W_DATA;
            W_RESP:  w_wnext = w_b_hs ? W_IDLE : W_RESP;
            default: w_wnext = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are 0 throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_werr    <= 1'b0;
            r_awid    <= '0;
            r_widx    <= '0;
            r_wburst  <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
        end else begin
            r_wstate  <= w_wnext;
            r_awready <= w_wnext == W_IDLE;
            r_wready  <= w_wnext == W_DATA;
            r_bvalid  <= w_wnext == W_RESP;
            if (w_aw_hs) begin
                r_awid   <= S_AXI_AWID;
                r_widx   <= S_AXI_AWADDR >> SHIFT;
                r_wburst <= S_AXI_AWBURST;
                r_wlen   <= S_AXI_AWLEN;
                r_wcnt   <= '0;
                r_werr   <= 1'b0;
            end
            if (w_w_hs) begin
                r_widx <= (r_wburst == 2'b00) ? r_widx : r_widx + ONE_A;
                r_wcnt <= r_wcnt + 8'd1;
                if (!w_win || (S_AXI_WLAST != w_wlast_beat))
                    r_werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && w_win)
            for (int b = 0; b < BYTES; b++)
                if (S_AXI_WSTRB[b])
                    r_mem[r_widx[IW-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BID     = r_awid;
    assign S_AXI_BRESP   = {r_bvalid & r_werr, 1'b0};

    assign w_ar_hs = r_arready & S_AXI_ARVALID;
    assign w_r_hs  = r_rvalid & S_AXI_RREADY;
    // A beat loads either when the latency count expires or straight after a non-final handshake.
    assign w_rload = (r_rstate == R_WAIT && r_lat == '0) || (r_rstate == R_DATA && w_r_hs && !r_rlast);
    assign w_lidx  = (r_rstate != R_DATA) ? r_ridx : (r_rburst == 2'b00) ? r_ridx : r_ridx + ONE_A;
    assign w_lcnt  = (r_rstate == R_DATA) ? r_rcnt + 8'd1 : r_rcnt;
    assign w_rin   = w_lidx < DEPTH_A;

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  w_rnext = w_ar_hs ? R_WAIT : R_IDLE;
            R_WAIT:  w_rnext = (r_lat == '0) ? R_DATA : R_WAIT;
            R_DATA:  w_rnext = (w_r_hs && r_rlast) ? R_IDLE : R_DATA;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Memory is sampled with the pre-edge contents, giving read-before-write on a same-word collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_arid    <= '0;
            r_ridx    <= '0;
            r_rburst  <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_lat     <= '0;
        end else begin
            r_rstate  <= w_rnext;
            r_arready <= w_rnext == R_IDLE;
            r_rvalid  <= w_rnext == R_DATA;
            if (w_ar_hs) begin
                r_arid   <= S_AXI_ARID;
                r_ridx   <= S_AXI_ARADDR >> SHIFT;
                r_rburst <= S_AXI_ARBURST;
                r_rlen   <= S_AXI_ARLEN;
                r_rcnt   <= '0;
                r_lat    <= 16'(READ_LATENCY - 1);
            end
            if (r_rstate == R_WAIT && r_lat != '0)
                r_lat <= r_lat - 16'd1;
            if (w_rload) begin
                r_ridx  <= w_lidx;
                r_rcnt  <= w_lcnt;
                r_rdata <= w_rin ? r_mem[w_lidx[IW-1:0]] : '0;
                r_rresp <= w_rin ? 2'b00 : 2'b10;
                r_rlast <= w_lcnt == r_rlen;
            end
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RID     = r_arid;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed bench for axi_mem_slave with single-beat vector table and burst sequences
module tb_axi_mem_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr, araddr;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [3:0]  awid, arid;
    logic [1:0]  awburst, arburst;
    logic [2:0]  awsize, arsize;
    logic [7:0]  awlen, arlen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [3:0]  bid, rid;
    logic [63:0] rdata;

    always #5 clk = ~clk;

    axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWID(awid), .S_AXI_AWBURST(awburst),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWLEN(awlen), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BID(bid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARID(arid),
        .S_AXI_ARBURST(arburst), .S_AXI_ARSIZE(arsize), .S_AXI_ARLEN(arlen), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RID(rid),
        .S_AXI_RLAST(rlast), .S_AXI_RREADY(rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        vt [7];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] wd [8];
    logic [63:0] exp_d [8];
    logic [1:0]  exp_r [8];
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;
    logic        got_bv_now;
    int          lat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [1:0] burst, input int nb, input int last_at, input logic [7:0] strb);
        int n;
        awaddr = a; awid = id; awlen = len; awburst = burst; awsize = 3'd3; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) timeout("wready");
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        got_bv_now = bvalid;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("bvalid");
        got_bid = bid; got_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [1:0] burst, input bit toggle);
        int n, beat;
        logic ph, v;
        araddr = a; arid = id; arlen = len; arburst = burst; arsize = 3'd3; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        beat = 0; ph = 1'b1; n = 0;
        while (beat <= int'(len) && n < 200) begin
            rready = toggle ? ph : 1'b1;
            v = rvalid;
            chk($sformatf("%s rvalid b%0d", tag, beat), rvalid, 1);
            chk($sformatf("%s rdata b%0d", tag, beat), rdata, exp_d[beat]);
            chk($sformatf("%s rresp b%0d", tag, beat), rresp, exp_r[beat]);
            chk($sformatf("%s rlast b%0d", tag, beat), rlast, beat == int'(len));
            chk($sformatf("%s rid b%0d", tag, beat), rid, id);
            @(posedge clk); #1;
            if (v && rready) beat++;
            ph = ~ph; n++;
        end
        if (n == 200) timeout("read beats");
        rready = 1'b0;
        chk($sformatf("%s rvalid after last", tag), rvalid, 0);
    endtask

    initial begin
        vt[0] = '{32'h200, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 2'b00, 2'b00};
        vt[1] = '{32'h200, 64'h0000000000000000, 8'h0F, 64'hFFFFFFFF00000000, 2'b00, 2'b00};
        vt[2] = '{32'h200, 64'h0123456789ABCDEF, 8'hF0, 64'h0123456700000000, 2'b00, 2'b00};
        vt[3] = '{32'h200, 64'hAAAAAAAAAAAAAAAA, 8'h00, 64'h0123456700000000, 2'b00, 2'b00};
        vt[4] = '{32'h208, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'hDEADBEEFCAFEF00D, 2'b00, 2'b00};
        vt[5] = '{32'h2000, 64'h1234123412341234, 8'hFF, 64'h0000000000000000, 2'b10, 2'b10};
        vt[6] = '{32'h1FF8, 64'h5555555555555555, 8'hFF, 64'h5555555555555555, 2'b00, 2'b00};

        awaddr = '0; awvalid = 0; awid = '0; awburst = 2'b01; awsize = 3'd3; awlen = '0;
        wdata = '0; wstrb = '0; wvalid = 0; wlast = 0; bready = 0;
        araddr = '0; arvalid = 0; arid = '0; arburst = 2'b01; arsize = 3'd3; arlen = '0; rready = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset awready", awready, 0);
        chk("reset arready", arready, 0);
        chk("reset wready", wready, 0);
        chk("reset bvalid", bvalid, 0);
        chk("reset rvalid", rvalid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first edge awready", awready, 1);
        chk("first edge arready", arready, 1);

        wd[0] = 64'h1122334455667788;
        wr(32'h40, 4'd3, 8'd0, 2'b01, 1, 0, 8'hFF);
        chk("single bvalid at end", got_bv_now, 1);
        chk("single bid", got_bid, 4'd3);
        chk("single bresp", got_bresp, 2'b00);
        exp_d[0] = 64'h1122334455667788; exp_r[0] = 2'b00;
        rd("single", 32'h40, 4'd5, 8'd0, 2'b01, 0);
        chk("read latency", lat, 2);

        for (int i = 0; i < 7; i++) begin
            wd[0] = vt[i].wdata;
            wr(vt[i].addr, 4'(i), 8'd0, 2'b01, 1, 0, vt[i].wstrb);
            chk($sformatf("vec%0d bid", i), got_bid, 4'(i));
            chk($sformatf("vec%0d bresp", i), got_bresp, vt[i].bresp);
            exp_d[0] = vt[i].rdata; exp_r[0] = vt[i].rresp;
            rd($sformatf("vec%0d", i), vt[i].addr, 4'(i + 8), 8'd0, 2'b01, 0);
        end

        for (int b = 0; b < 4; b++) begin
            wd[b] = 64'hA0 + 64'(b); exp_d[b] = wd[b]; exp_r[b] = 2'b00;
        end
        wr(32'h100, 4'd7, 8'd3, 2'b01, 4, 3, 8'hFF);
        chk("incr bresp", got_bresp, 2'b00);
        rd("incr toggle", 32'h100, 4'd9, 8'd3, 2'b01, 1);

        wd[0] = 64'hD0D0D0D0D0D0D0D0; wd[1] = 64'hD1D1D1D1D1D1D1D1;
        wr(32'h1FF8, 4'd2, 8'd1, 2'b01, 2, 1, 8'hFF);
        chk("edge bresp", got_bresp, 2'b10);
        exp_d[0] = wd[0]; exp_r[0] = 2'b00; exp_d[1] = '0; exp_r[1] = 2'b10;
        rd("edge", 32'h1FF8, 4'd4, 8'd1, 2'b01, 0);

        wd[0] = 64'hE0; wd[1] = 64'hE1;
        wr(32'h300, 4'd6, 8'd3, 2'b01, 2, 1, 8'hFF);
        chk("early wlast bvalid", got_bv_now, 1);
        chk("early wlast bresp", got_bresp, 2'b10);
        wr(32'h310, 4'd6, 8'd1, 2'b01, 2, -1, 8'hFF);
        chk("no wlast bvalid", got_bv_now, 1);
        chk("no wlast bresp", got_bresp, 2'b10);

        wd[0] = 64'h8888888888888888;
        wr(32'h88, 4'd1, 8'd0, 2'b01, 1, 0, 8'hFF);
        wd[0] = 64'hB0; wd[1] = 64'hB1; wd[2] = 64'hB2;
        wr(32'h80, 4'd1, 8'd2, 2'b00, 3, 2, 8'hFF);
        chk("fixed bresp", got_bresp, 2'b00);
        exp_d[0] = 64'hB2; exp_r[0] = 2'b00;
        rd("fixed", 32'h80, 4'd1, 8'd0, 2'b01, 0);
        exp_d[0] = 64'h8888888888888888;
        rd("fixed neighbour", 32'h88, 4'd1, 8'd0, 2'b01, 0);

        araddr = 32'h100; arid = 4'd12; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        begin
            int n;
            n = 0;
            while (!arready && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) timeout("arready pre-reset");
            @(posedge clk); #1;
            arvalid = 1'b0;
            n = 0;
            while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
            chk("pre-reset rvalid", rvalid, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset rvalid", rvalid, 0);
        chk("mid-reset rlast", rlast, 0);
        chk("mid-reset rdata", rdata, 64'h0);
        chk("mid-reset arready", arready, 0);
        @(negedge clk) rst_n = 1'b1;
        exp_d[0] = 64'h1122334455667788; exp_r[0] = 2'b00;
        rd("post-reset", 32'h40, 4'd13, 8'd0, 2'b01, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("no stale beat %0d", k), rvalid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
